// File: rtl/decode_issue_ctrl.sv
// In-order fetch->decode instruction queue with a RUN/HALT issue sequencer.
// A funct3=0 SYSTEM word is issued, then issue stops until resume or flush.
module decode_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [XLEN-1:0]          fetch_pc,
  input  logic [31:0]              fetch_instr,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [XLEN-1:0]          dec_pc,
  output logic [31:0]              dec_instr,
  input  logic                     flush,
  input  logic                     resume,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  state_t         state, state_nx;
  logic           empty, full, push, pop, is_sys;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // fetch_ready deliberately ignores dec_ready: no decode->fetch comb path
  assign fetch_ready = rst & ~full & ~flush;
  assign dec_valid   = ~empty & (state == RUN) & ~flush;
  assign push        = fetch_valid & fetch_ready;
  assign pop         = dec_valid & dec_ready;

  assign dec_pc    = empty ? '0 : head.pc;
  assign dec_instr = empty ? '0 : head.instr;
  assign halted    = (state == HALT);

  assign is_sys = (head.instr[6:0] == 7'b1110011) && (head.instr[14:12] == 3'b000);

  always_comb begin
    state_nx = state;
    if (flush) state_nx = RUN;
    else begin
      case (state)
        RUN:  if (pop && is_sys) state_nx = HALT;
        HALT: if (resume)        state_nx = RUN;
        default:                 state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: fetch_pc, instr: fetch_instr};
  end
endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Instruction queue and issue sequencer between instruction fetch and the decode stage. It buffers fetched {pc, instruction} pairs in an in-order FIFO and presents the head entry to decode over a valid/ready handshake. Pipeline flushes clear the queue. A two-state FSM halts issue after an ECALL/EBREAK is handed to decode, until the core resumes it.

Parameters:
XLEN, 32, width of the program counter
DEPTH, 4, queue entries; power of two, minimum 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
fetch_valid  in  1  fetch presents an entry
fetch_ready  out  1  queue accepts an entry this cycle
fetch_pc  in  XLEN  PC of the fetched instruction
fetch_instr  in  32  fetched instruction word
dec_valid  out  1  head entry offered to decode
dec_ready  in  1  decode consumes the head entry
dec_pc  out  XLEN  PC of the head entry
dec_instr  out  32  instruction of the head entry
flush  in  1  synchronous queue clear (redirect or trap)
resume  in  1  leave HALT
halted  out  1  FSM is in HALT
count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (rst=0, asynchronous):
  - read pointer, write pointer and count go to 0; FSM goes to RUN.
  - fetch_ready=0, dec_valid=0, dec_pc=0, dec_instr=0, halted=0.
  - Storage contents are don't-care.
  - Reset asserted mid-transfer drops all entries.
- push = fetch_valid & fetch_ready.
  - fetch_ready = rst & (count<DEPTH) & ~flush.
  - fetch_ready does not depend on dec_ready, so there is no combinational path from decode back to fetch.
  - When full, a push is never accepted, even if a pop happens in the same cycle.
- pop = dec_valid & dec_ready.
  - dec_valid = (count!=0) & (state==RUN) & ~flush.
  - dec_pc and dec_instr come combinationally from the head entry; they read 0 when count==0.
- Latency: an entry pushed at edge N is visible on dec_valid in the cycle after edge N. There is no bypass from fetch to decode in the same cycle.
- Handshake stability: while dec_valid=1 and dec_ready=0, dec_pc and dec_instr hold stable. Decode may drop dec_ready at any time.
- Counting:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - FIFO order is strictly preserved.
- Flush (highest priority over push, pop and FSM):
  - In a cycle with flush=1, no push and no pop occur.
  - At the next edge, pointers and count go to 0 and the FSM goes to RUN, which clears halted.
  - A fetch_valid in the same cycle as flush is dropped.
- FSM:
  - RUN -> HALT at the edge where a pop completes and the popped word has opcode[6:0]=7'b1110011 and funct3[14:12]=3'b000 (ECALL, EBREAK, and other funct3=0 SYSTEM words).
  - The SYSTEM instruction itself is issued. In the following cycle halted=1 and dec_valid=0.
  - HALT: pushes continue until the queue is full; no pops.
  - HALT -> RUN at the edge where resume=1. The earliest issue is the cycle after that edge.
  - resume in RUN is ignored.
  - If flush and resume are high together, flush governs; the result is RUN with the queue empty.
- halted = (state==HALT), decoded from the state register.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with fetch_valid=1 -> fetch_ready=0, dec_valid=0, count=0, halted=0, dec_instr=0. Release rst=1 -> fetch_ready=1, dec_valid=0.
2. Single entry: push pc=0x0, instr=0x0F0F0037 (LUI) with dec_ready=0 -> next cycle dec_valid=1, dec_instr=0x0F0F0037, count=1. Values hold for 3 cycles. Set dec_ready=1 -> one pop, then count=0, dec_valid=0.
3. Full and ordering: push pc 0x0, 0x4, 0x8, 0xC with dec_ready=0 -> count=4, fetch_ready=0; a fifth fetch_valid is not accepted. Then dec_ready=1 -> pops return pc 0x0, 0x4, 0x8, 0xC in order; fetch_ready=1 the cycle after the first pop.
4. Simultaneous push and pop at count=2 with continuous streaming for 10 cycles -> count stays 2, PCs leave in push order, pointers wrap with no loss.
5. Halt and resume: queue holds 0x00000073 (ECALL, pc 0x10) then 0x0F0F0017 (AUIPC, pc 0x14), dec_ready=1 -> ECALL popped; next cycle halted=1, dec_valid=0, count=1. Pulse resume=1 -> following cycle dec_valid=1, dec_instr=0x0F0F0017, halted=0.
6. Flush: count=3 and halted=1; assert flush with fetch_valid=1 -> during flush, fetch_ready=0 and dec_valid=0. Next cycle count=0, halted=0, dec_valid=0, and the concurrent fetch entry is absent.
